// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and main-memory ports of mem_arbiter.
// slave is the arbiter's view; master is the caches-plus-memory environment.
interface mem_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) ();

   logic              I_READ;
   logic [ADDR_W-1:0] I_ADDRESS;
   logic [DATA_W-1:0] I_READDATA;
   logic              I_BUSYWAIT;

   logic              D_READ;
   logic              D_WRITE;
   logic [ADDR_W-1:0] D_ADDRESS;
   logic [DATA_W-1:0] D_WRITEDATA;
   logic [DATA_W-1:0] D_READDATA;
   logic              D_BUSYWAIT;

   logic              M_READ;
   logic              M_WRITE;
   logic [ADDR_W-1:0] M_ADDRESS;
   logic [DATA_W-1:0] M_WRITEDATA;
   logic [DATA_W-1:0] M_READDATA;
   logic              M_BUSYWAIT;

   modport slave (
      input  I_READ, I_ADDRESS,
      output I_READDATA, I_BUSYWAIT,
      input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
      output D_READDATA, D_BUSYWAIT,
      output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
      input  M_READDATA, M_BUSYWAIT
   );

   modport master (
      output I_READ, I_ADDRESS,
      input  I_READDATA, I_BUSYWAIT,
      output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
      input  D_READDATA, D_BUSYWAIT,
      input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
      output M_READDATA, M_BUSYWAIT
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single shared main memory.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed data-port priority.
//
// state  | meaning
// IDLE   | no access in flight; grants a pending request at the next edge
// I_ACC  | instruction read in flight on the memory port
// D_ACC  | data read or write in flight on the memory port
// I_DONE | one-cycle completion window, I_BUSYWAIT released
// D_DONE | one-cycle completion window, D_BUSYWAIT released
module mem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic          CLK,
   input  logic          RESETN,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_I_ACC  = 3'd1,
      ST_D_ACC  = 3'd2,
      ST_I_DONE = 3'd3,
      ST_D_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              busy_seen_q, busy_seen_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic i_req;
   logic d_req;
   logic pick_d;
   logic done_hit;
   logic in_acc;

   assign i_req    = bus.I_READ;
   assign d_req    = bus.D_READ | bus.D_WRITE;
   assign in_acc   = (state_q == ST_I_ACC) || (state_q == ST_D_ACC);
   // Memory must have been seen busy at least once before a low busywait counts as done.
   assign done_hit = busy_seen_q & ~bus.M_BUSYWAIT;

`ifdef MEM_ARB_RR_EN
   logic last_d_q, last_d_d;

   assign pick_d = d_req & (~i_req | ~last_d_q);

   always_comb begin
      last_d_d = last_d_q;
      if ((state_q == ST_IDLE) && (i_req | d_req)) begin
         last_d_d = pick_d;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         last_d_q <= 1'b0;
      end else begin
         last_d_q <= last_d_d;
      end
   end
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         busy_seen_q <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         busy_seen_q <= busy_seen_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req | d_req) begin
               state_d = pick_d ? ST_D_ACC : ST_I_ACC;
            end
         end
         ST_I_ACC: begin
            if (done_hit) begin
               state_d = ST_I_DONE;
            end
         end
         ST_D_ACC: begin
            if (done_hit) begin
               state_d = ST_D_DONE;
            end
         end
         ST_I_DONE: state_d = ST_IDLE;
         ST_D_DONE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request fields are captured once at grant so requester changes mid-access are ignored.
   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      busy_seen_d = busy_seen_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req | d_req) begin
               addr_d      = pick_d ? bus.D_ADDRESS : bus.I_ADDRESS;
               wdata_d     = pick_d ? bus.D_WRITEDATA : '0;
               wr_d        = pick_d & bus.D_WRITE;
               busy_seen_d = 1'b0;
            end
         end
         ST_I_ACC, ST_D_ACC: begin
            if (done_hit) begin
               busy_seen_d = 1'b0;
               if (!wr_q) begin
                  if (state_q == ST_I_ACC) begin
                     i_rdata_d = bus.M_READDATA;
                  end else begin
                     d_rdata_d = bus.M_READDATA;
                  end
               end
            end else if (bus.M_BUSYWAIT) begin
               busy_seen_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.M_READ      = 1'b0;
      bus.M_WRITE     = 1'b0;
      if (in_acc) begin
         bus.M_READ  = ~wr_q;
         bus.M_WRITE = wr_q;
      end
      bus.M_ADDRESS   = addr_q;
      bus.M_WRITEDATA = wdata_q;
      bus.I_READDATA  = i_rdata_q;
      bus.D_READDATA  = d_rdata_q;
      bus.I_BUSYWAIT  = i_req & (state_q != ST_I_DONE);
      bus.D_BUSYWAIT  = d_req & (state_q != ST_D_DONE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of grant order,
// completion timing, memory contents and read-data registers.
module tb_mem_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK    (clk),
      .RESETN (rst_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   acc_t          mlog[$];
   logic [DW-1:0] mem     [64];
   logic [DW-1:0] ref_mem [64];
   int            mem_lat = 1;
   int            busy_cnt = 0;
   bit            logged = 1'b0;

   int            n_cmp = 0;
   int            n_err = 0;
   bit            last_d = 1'b0;
   logic [DW-1:0] exp_ir = '0;
   logic [DW-1:0] exp_dr = '0;

   // Main memory: busy for mem_lat edges per access, then answers and records the access.
   always @(negedge clk) begin
      if (bus.M_READ || bus.M_WRITE) begin
         if (bus.M_BUSYWAIT) busy_cnt++;
         if (busy_cnt < mem_lat) begin
            bus.M_BUSYWAIT = 1'b1;
            bus.M_READDATA = $urandom;
         end else begin
            bus.M_BUSYWAIT = 1'b0;
            bus.M_READDATA = mem[bus.M_ADDRESS];
            if (!logged) begin
               mlog.push_back('{bus.M_WRITE, bus.M_READ, bus.M_ADDRESS, bus.M_WRITEDATA});
               if (bus.M_WRITE) mem[bus.M_ADDRESS] = bus.M_WRITEDATA;
               logged = 1'b1;
            end
         end
      end else begin
         busy_cnt       = 0;
         logged         = 1'b0;
         bus.M_BUSYWAIT = 1'b0;
         bus.M_READDATA = $urandom;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_log(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      acc_t got;
      if (mlog.size() == 0) begin
         chk("mlog_missing", 32'd0, 32'd1);
      end else begin
         got = mlog.pop_front();
         chk("m_write", {31'd0, got.wr}, {31'd0, wr});
         chk("m_read", {31'd0, got.rd}, {31'd0, ~wr});
         chk("m_addr", {26'd0, got.addr}, {26'd0, addr});
         if (wr) chk("m_wdata", got.data, data);
      end
   endtask

   // One arbitration round: optional I read and optional D access raised together.
   task automatic run_scn(input bit hi, input bit hd, input bit drd, input bit dwr,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [DW-1:0] dw, input int lat, input bit scr);
      bit   first_d, serve_d, pend_i, pend_d;
      int   t_i, t_d, cyc;
      acc_t exp_q[$];
      acc_t e;
`ifdef MEM_ARB_RR_EN
      first_d = hd && (!hi || !last_d);
`else
      first_d = hd;
`endif
      t_i = -1;
      t_d = -1;
      for (int k = 0; k < 2; k++) begin
         serve_d = (k == 0) ? first_d : !first_d;
         if (serve_d && hd) begin
            t_d = (k == 0) ? lat + 2 : t_i + lat + 3;
            if (dwr) ref_mem[da] = dw;
            else     exp_dr = ref_mem[da];
            exp_q.push_back('{dwr, !dwr, da, dw});
            last_d = 1'b1;
         end else if (!serve_d && hi) begin
            t_i = (k == 0) ? lat + 2 : t_d + lat + 3;
            exp_ir = ref_mem[ia];
            exp_q.push_back('{1'b0, 1'b1, ia, '0});
            last_d = 1'b0;
         end
      end

      mem_lat         = lat;
      bus.I_READ      = hi;
      bus.I_ADDRESS   = ia;
      bus.D_READ      = hd & drd;
      bus.D_WRITE     = hd & dwr;
      bus.D_ADDRESS   = da;
      bus.D_WRITEDATA = dw;
      pend_i = hi;
      pend_d = hd;
      cyc    = 0;
      while ((pend_i || pend_d) && cyc < 100) begin
         tick();
         cyc++;
         if (pend_i && !bus.I_BUSYWAIT) begin
            chk("i_done_cycle", cyc, t_i);
            chk("i_readdata", bus.I_READDATA, exp_ir);
            bus.I_READ = 1'b0;
            pend_i     = 1'b0;
         end
         if (pend_d && !bus.D_BUSYWAIT) begin
            chk("d_done_cycle", cyc, t_d);
            chk("d_readdata", bus.D_READDATA, exp_dr);
            bus.D_READ  = 1'b0;
            bus.D_WRITE = 1'b0;
            pend_d      = 1'b0;
         end
         if (scr && first_d && pend_d) begin
            bus.D_ADDRESS   = AW'($urandom);
            bus.D_WRITEDATA = $urandom;
         end else if (scr && !first_d && pend_i) begin
            bus.I_ADDRESS = AW'($urandom);
         end
      end
      chk("scn_timeout", {31'd0, pend_i | pend_d}, 32'd0);
      bus.I_READ  = 1'b0;
      bus.D_READ  = 1'b0;
      bus.D_WRITE = 1'b0;
      tick();
      chk("mlog_count", mlog.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_log(e.wr, e.addr, e.data);
      end
      mlog.delete();
   endtask

   initial begin
      int            cyc, nrd, nbw;
      bit            hi, hd;
      int            op;
      logic [AW-1:0] ia, da;
      logic [DW-1:0] dw;

      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[5]     = 32'hDEAD_BEEF;
      ref_mem[5] = 32'hDEAD_BEEF;

      rst_n           = 1'b1;
      bus.I_READ      = 1'b1;
      bus.I_ADDRESS   = 6'h11;
      bus.D_READ      = 1'b1;
      bus.D_WRITE     = 1'b0;
      bus.D_ADDRESS   = 6'h22;
      bus.D_WRITEDATA = 32'h0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_m_read", {31'd0, bus.M_READ}, 32'd0);
      chk("rst_m_write", {31'd0, bus.M_WRITE}, 32'd0);
      chk("rst_m_addr", {26'd0, bus.M_ADDRESS}, 32'd0);
      chk("rst_m_wdata", bus.M_WRITEDATA, 32'd0);
      chk("rst_i_rdata", bus.I_READDATA, 32'd0);
      chk("rst_d_rdata", bus.D_READDATA, 32'd0);
      chk("rst_i_busy", {31'd0, bus.I_BUSYWAIT}, 32'd1);
      chk("rst_d_busy", {31'd0, bus.D_BUSYWAIT}, 32'd1);
      bus.I_READ = 1'b0;
      bus.D_READ = 1'b0;
      rst_n      = 1'b1;
      tick();

      // Single data read, memory busy 5 edges.
      mem_lat       = 5;
      bus.D_READ    = 1'b1;
      bus.D_ADDRESS = 6'h05;
      cyc = 0;
      nrd = 0;
      do begin
         tick();
         cyc++;
         if (bus.M_READ) nrd++;
      end while (bus.D_BUSYWAIT && cyc < 40);
      chk("dread_done_cycle", cyc, 7);
      chk("dread_mread_cycles", nrd, 6);
      chk("dread_data", bus.D_READDATA, 32'hDEAD_BEEF);
      tick();
      chk("dread_busy_one_cycle", {31'd0, bus.D_BUSYWAIT}, 32'd1);
      bus.D_READ = 1'b0;
      tick();
      exp_dr = 32'hDEAD_BEEF;
      last_d = 1'b1;
      chk("dread_mlog_count", mlog.size(), 1);
      chk_log(1'b0, 6'h05, '0);
      mlog.delete();

      // Contention, repeated twice: grant order comes from the model's policy.
      run_scn(1'b1, 1'b1, 1'b0, 1'b1, 6'h01, 6'h02, 32'hA5A5_0002, 2, 1'b0);
      run_scn(1'b1, 1'b1, 1'b0, 1'b1, 6'h01, 6'h02, 32'h5A5A_0002, 2, 1'b0);

      // Read+write together is a write.
      run_scn(1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 6'h3F, 32'h1234_5678, 3, 1'b0);

      // Instruction request withdrawn during the access.
      ia            = 6'h09;
      mem_lat       = 4;
      bus.I_READ    = 1'b1;
      bus.I_ADDRESS = ia;
      tick();
      tick();
      bus.I_READ = 1'b0;
      nbw = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.I_BUSYWAIT) nbw++;
      end
      exp_ir = ref_mem[ia];
      last_d = 1'b0;
      chk("iwd_busy_cycles", nbw, 0);
      chk("iwd_readdata", bus.I_READDATA, exp_ir);
      chk("iwd_mlog_count", mlog.size(), 1);
      chk_log(1'b0, ia, '0);
      mlog.delete();

      // Reset two cycles into a data write; the held request is served again afterwards.
      da              = 6'h2A;
      dw              = $urandom;
      mem_lat         = 8;
      bus.D_WRITE     = 1'b1;
      bus.D_ADDRESS   = da;
      bus.D_WRITEDATA = dw;
      tick();
      tick();
      tick();
      chk("rmid_mwrite_before", {31'd0, bus.M_WRITE}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rmid_mwrite", {31'd0, bus.M_WRITE}, 32'd0);
      chk("rmid_mread", {31'd0, bus.M_READ}, 32'd0);
      chk("rmid_maddr", {26'd0, bus.M_ADDRESS}, 32'd0);
      chk("rmid_d_busy", {31'd0, bus.D_BUSYWAIT}, 32'd1);
      chk("rmid_d_rdata", bus.D_READDATA, 32'd0);
      chk("rmid_i_rdata", bus.I_READDATA, 32'd0);
      exp_dr = '0;
      exp_ir = '0;
      last_d = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rmid_no_commit", mlog.size(), 0);
      run_scn(1'b0, 1'b1, 1'b0, 1'b1, 6'h00, da, dw, 2, 1'b0);

      // Randomized rounds.
      for (int n = 0; n < 40; n++) begin
         hi = 1'($urandom_range(0, 1));
         hd = 1'($urandom_range(0, 1));
         if (!hi && !hd) hi = 1'b1;
         op = $urandom_range(0, 2);
         ia = AW'($urandom_range(0, 7));
         da = AW'($urandom_range(0, 7));
         dw = $urandom;
         run_scn(hi, hd, op != 1, op != 0, ia, da, dw, $urandom_range(1, 5),
                 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
